// File: rtl/multicycle_maindec.sv
// Multicycle MIPS main decoder: Moore FSM sequencing fetch/decode/execute/memory/writeback.
// Latency: outputs follow the registered state; irwrite/pcwrite in FETCH also follow mem_ready combinationally.
// Backpressure: FETCH, MEMRD and MEMWR hold their state and strobes until mem_ready (when MEM_HANDSHAKE=1).
module multicycle_maindec #(
    parameter bit EN64          = 1'b1,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       branch,
    output logic       branchne,
    output logic       iord,
    output logic       irwrite,
    output logic       memread,
    output logic       memwrite,
    output logic [1:0] memsize,
    output logic       loadsigned,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] aluop,
    output logic       illegal,
    output logic [3:0] state_o
);

    // State encoding is visible on state_o, so values are pinned explicitly.
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_ALUWB  = 4'd7,
        S_IEXEC  = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LD    = 6'b110111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SD    = 6'b111111;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_DADDI = 6'b011000;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_AND   = 3'b001;
    localparam logic [2:0] ALU_OR    = 3'b010;
    localparam logic [2:0] ALU_SLT   = 3'b011;
    localparam logic [2:0] ALU_SUB   = 3'b100;
    localparam logic [2:0] ALU_FUNCT = 3'b111;

    localparam logic [1:0] MS_BYTE  = 2'b00;
    localparam logic [1:0] MS_WORD  = 2'b01;
    localparam logic [1:0] MS_DWORD = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    state_t state_q;
    state_t state_d;

    logic       mem_rdy_eff;
    logic       op_load;
    logic       op_store;
    logic       op_rtype;
    logic       op_imm;
    logic       op_branch;
    logic       op_jump;
    logic [1:0] dec_memsize;
    logic       dec_signed;
    logic [2:0] dec_imm_aluop;

    // Without a handshake every memory access is assumed to finish in one cycle.
    assign mem_rdy_eff = MEM_HANDSHAKE ? mem_ready : 1'b1;

    // Opcode classification; 64-bit opcodes only classify as legal when EN64 is set.
    always_comb begin
        op_load       = 1'b0;
        op_store      = 1'b0;
        op_rtype      = 1'b0;
        op_imm        = 1'b0;
        op_branch     = 1'b0;
        op_jump       = 1'b0;
        dec_memsize   = MS_BYTE;
        dec_signed    = 1'b0;
        dec_imm_aluop = ALU_ADD;
        case (op)
            OP_RTYPE: op_rtype = 1'b1;
            OP_LW: begin
                op_load     = 1'b1;
                dec_memsize = MS_WORD;
            end
            OP_LD: begin
                op_load     = EN64;
                dec_memsize = MS_DWORD;
            end
            OP_LB: begin
                op_load     = 1'b1;
                dec_memsize = MS_BYTE;
                dec_signed  = 1'b1;
            end
            OP_LBU: begin
                op_load     = 1'b1;
                dec_memsize = MS_BYTE;
            end
            OP_SW: begin
                op_store    = 1'b1;
                dec_memsize = MS_WORD;
            end
            OP_SD: begin
                op_store    = EN64;
                dec_memsize = MS_DWORD;
            end
            OP_SB: begin
                op_store    = 1'b1;
                dec_memsize = MS_BYTE;
            end
            OP_BEQ:  op_branch = 1'b1;
            OP_BNE:  op_branch = 1'b1;
            OP_J:    op_jump   = 1'b1;
            OP_ADDI: begin
                op_imm        = 1'b1;
                dec_imm_aluop = ALU_ADD;
            end
            OP_DADDI: begin
                op_imm        = EN64;
                dec_imm_aluop = ALU_ADD;
            end
            OP_ANDI: begin
                op_imm        = 1'b1;
                dec_imm_aluop = ALU_AND;
            end
            OP_ORI: begin
                op_imm        = 1'b1;
                dec_imm_aluop = ALU_OR;
            end
            OP_SLTI: begin
                op_imm        = 1'b1;
                dec_imm_aluop = ALU_SLT;
            end
            default: ;
        endcase
    end

    // State register; reset abandons any in-flight access and restarts at FETCH.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore control outputs; everything defaults to inactive.
    always_comb begin
        state_d    = state_q;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        branchne   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        memsize    = MS_BYTE;
        loadsigned = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_RT;
        pcsrc      = PCSRC_ALU;
        aluop      = ALU_ADD;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                // PC+4 is computed every fetch cycle but only committed with the IR.
                memread = 1'b1;
                alusrcb = SRCB_FOUR;
                irwrite = mem_rdy_eff;
                pcwrite = mem_rdy_eff;
                if (mem_rdy_eff) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculatively form the branch target into ALUOut.
                alusrcb = SRCB_IMMSL2;
                if (op_load || op_store) begin
                    state_d = S_MEMADR;
                end else if (op_rtype) begin
                    state_d = S_REXEC;
                end else if (op_imm) begin
                    state_d = S_IEXEC;
                end else if (op_branch) begin
                    state_d = S_BRANCH;
                end else if (op_jump) begin
                    state_d = S_JUMP;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                state_d = op_store ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                memread    = 1'b1;
                iord       = 1'b1;
                memsize    = dec_memsize;
                loadsigned = dec_signed;
                if (mem_rdy_eff) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                // Size/sign kept stable so the MDR extension logic stays valid.
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                memsize    = dec_memsize;
                loadsigned = dec_signed;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                // Strobe held across wait states; the access completes once on mem_ready.
                memwrite = 1'b1;
                iord     = 1'b1;
                memsize  = dec_memsize;
                if (mem_rdy_eff) begin
                    state_d = S_FETCH;
                end
            end
            S_REXEC: begin
                alusrca = 1'b1;
                aluop   = ALU_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                state_d  = S_FETCH;
            end
            S_IEXEC: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                aluop   = dec_imm_aluop;
                state_d = S_IWB;
            end
            S_IWB: begin
                regwrite = 1'b1;
                aluop    = dec_imm_aluop;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                alusrca  = 1'b1;
                aluop    = ALU_SUB;
                pcsrc    = PCSRC_ALUOUT;
                branch   = (op == OP_BEQ);
                branchne = (op == OP_BNE);
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                pcwrite = 1'b1;
                pcsrc   = PCSRC_JUMP;
                state_d = S_FETCH;
            end
            S_TRAP: begin
                // Sticky until reset; no write enable may leak out of here.
                illegal = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_maindec.sv
// Directed bench for multicycle_maindec: per-cycle state and full control-word checks.
// Latency: each step samples outputs 2 time units after the rising edge.
// Backpressure: mem_ready is driven low in FETCH/MEMRD/MEMWR to exercise wait states.
module tb_multicycle_maindec;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_REXEC  = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_IEXEC  = 4'd8;
    localparam logic [3:0] S_IWB    = 4'd9;
    localparam logic [3:0] S_BRANCH = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_TRAP   = 4'd12;

    // Control word field masks (bit layout matches the ctl concatenation below).
    localparam logic [21:0] PCW      = 22'd1 << 21;
    localparam logic [21:0] BRQ      = 22'd1 << 20;
    localparam logic [21:0] BRNE     = 22'd1 << 19;
    localparam logic [21:0] IORD     = 22'd1 << 18;
    localparam logic [21:0] IRW      = 22'd1 << 17;
    localparam logic [21:0] MRD      = 22'd1 << 16;
    localparam logic [21:0] MWR      = 22'd1 << 15;
    localparam logic [21:0] MS_W     = 22'd1 << 13;
    localparam logic [21:0] MS_D     = 22'd2 << 13;
    localparam logic [21:0] LSG      = 22'd1 << 12;
    localparam logic [21:0] RW       = 22'd1 << 11;
    localparam logic [21:0] RDST     = 22'd1 << 10;
    localparam logic [21:0] M2R      = 22'd1 << 9;
    localparam logic [21:0] ASA      = 22'd1 << 8;
    localparam logic [21:0] SB4      = 22'd1 << 6;
    localparam logic [21:0] SBI      = 22'd2 << 6;
    localparam logic [21:0] SBI2     = 22'd3 << 6;
    localparam logic [21:0] PCALUOUT = 22'd1 << 4;
    localparam logic [21:0] PCJ      = 22'd2 << 4;
    localparam logic [21:0] OP_OR    = 22'd2 << 1;
    localparam logic [21:0] OP_SUB   = 22'd4 << 1;
    localparam logic [21:0] OP_FN    = 22'd7 << 1;
    localparam logic [21:0] ILL      = 22'd1;

    // Hand-built expected control words.
    localparam logic [21:0] W_FNR = MRD | SB4;
    localparam logic [21:0] W_FR  = MRD | SB4 | IRW | PCW;
    localparam logic [21:0] W_DEC = SBI2;
    localparam logic [21:0] W_MA  = ASA | SBI;
    localparam logic [21:0] W_REX = ASA | OP_FN;
    localparam logic [21:0] W_AWB = RW | RDST;
    localparam logic [21:0] W_RDB = MRD | IORD | LSG;
    localparam logic [21:0] W_WBB = RW | M2R | LSG;
    localparam logic [21:0] W_WRD = MWR | IORD | MS_D;
    localparam logic [21:0] W_WRW = MWR | IORD | MS_W;
    localparam logic [21:0] W_BNE = ASA | OP_SUB | PCALUOUT | BRNE;
    localparam logic [21:0] W_J   = PCW | PCJ;
    localparam logic [21:0] W_IEX = ASA | SBI | OP_OR;
    localparam logic [21:0] W_IWB = RW | OP_OR;
    localparam logic [21:0] W_ILL = ILL;

    logic clk;
    logic reset, mem_ready;
    logic [5:0] op;
    logic pcwrite, branch, branchne, iord, irwrite, memread, memwrite;
    logic [1:0] memsize, alusrcb, pcsrc;
    logic loadsigned, regwrite, regdst, memtoreg, alusrca, illegal;
    logic [2:0] aluop;
    logic [3:0] state_o;

    logic reset32, mem_ready32;
    logic [5:0] op32;
    logic pcwrite32, branch32, branchne32, iord32, irwrite32, memread32, memwrite32;
    logic [1:0] memsize32, alusrcb32, pcsrc32;
    logic loadsigned32, regwrite32, regdst32, memtoreg32, alusrca32, illegal32;
    logic [2:0] aluop32;
    logic [3:0] state32;

    logic [21:0] ctl, ctl32;
    assign ctl = {pcwrite, branch, branchne, iord, irwrite, memread, memwrite, memsize,
                  loadsigned, regwrite, regdst, memtoreg, alusrca, alusrcb, pcsrc, aluop, illegal};
    assign ctl32 = {pcwrite32, branch32, branchne32, iord32, irwrite32, memread32, memwrite32,
                    memsize32, loadsigned32, regwrite32, regdst32, memtoreg32, alusrca32,
                    alusrcb32, pcsrc32, aluop32, illegal32};

    int checks = 0;
    int errors = 0;
    logic count_en = 1'b0;
    int irw_cnt = 0;
    int mw32_cnt = 0;

    multicycle_maindec #(.EN64(1'b1), .MEM_HANDSHAKE(1'b1)) u_dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .branch(branch), .branchne(branchne), .iord(iord),
        .irwrite(irwrite), .memread(memread), .memwrite(memwrite), .memsize(memsize),
        .loadsigned(loadsigned), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
        .illegal(illegal), .state_o(state_o)
    );

    multicycle_maindec #(.EN64(1'b0), .MEM_HANDSHAKE(1'b1)) u_dut32 (
        .clk(clk), .reset(reset32), .op(op32), .mem_ready(mem_ready32),
        .pcwrite(pcwrite32), .branch(branch32), .branchne(branchne32), .iord(iord32),
        .irwrite(irwrite32), .memread(memread32), .memwrite(memwrite32), .memsize(memsize32),
        .loadsigned(loadsigned32), .regwrite(regwrite32), .regdst(regdst32),
        .memtoreg(memtoreg32), .alusrca(alusrca32), .alusrcb(alusrcb32), .pcsrc(pcsrc32),
        .aluop(aluop32), .illegal(illegal32), .state_o(state32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mid-cycle monitors for pulse counts.
    always @(negedge clk) begin
        if (count_en && irwrite) irw_cnt++;
        if (memwrite32) mw32_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag, input logic [3:0] st, input logic [21:0] w);
        #1;
        check({tag, "_state"}, {28'd0, state_o}, {28'd0, st});
        check({tag, "_ctl"}, {10'd0, ctl}, {10'd0, w});
    endtask

    task automatic cyc32(input string tag, input logic [3:0] st, input logic [21:0] w);
        #1;
        check({tag, "_state"}, {28'd0, state32}, {28'd0, st});
        check({tag, "_ctl"}, {10'd0, ctl32}, {10'd0, w});
    endtask

    initial begin
        reset = 1'b0; mem_ready = 1'b0; op = 6'b000000;
        reset32 = 1'b0; mem_ready32 = 1'b0; op32 = 6'b000000;

        // Reset state.
        tick();
        cyc("reset", S_FETCH, W_FNR);
        cyc32("reset32", S_FETCH, W_FNR);

        // ADD, zero wait states: 4 cycles.
        reset = 1'b1; op = 6'b000000; mem_ready = 1'b1;
        cyc("add_c1", S_FETCH, W_FR);
        tick(); cyc("add_c2", S_DECODE, W_DEC);
        tick(); cyc("add_c3", S_REXEC, W_REX);
        tick(); cyc("add_c4", S_ALUWB, W_AWB);

        // LB with two wait cycles in FETCH and in MEMRD: 9 cycles.
        tick(); op = 6'b100000; mem_ready = 1'b0; count_en = 1'b1;
        cyc("lb_c1", S_FETCH, W_FNR);
        tick(); cyc("lb_c2", S_FETCH, W_FNR);
        tick(); mem_ready = 1'b1; cyc("lb_c3", S_FETCH, W_FR);
        tick(); mem_ready = 1'b0; cyc("lb_c4", S_DECODE, W_DEC);
        tick(); cyc("lb_c5", S_MEMADR, W_MA);
        tick(); cyc("lb_c6", S_MEMRD, W_RDB);
        tick(); cyc("lb_c7", S_MEMRD, W_RDB);
        tick(); mem_ready = 1'b1; cyc("lb_c8", S_MEMRD, W_RDB);
        tick(); cyc("lb_c9", S_MEMWB, W_WBB);

        // SD with EN64=1, one wait cycle in MEMWR.
        tick(); count_en = 1'b0; op = 6'b111111; mem_ready = 1'b1;
        cyc("sd_c1", S_FETCH, W_FR);
        check("lb_irwrite_pulses", irw_cnt, 1);
        tick(); cyc("sd_c2", S_DECODE, W_DEC);
        tick(); cyc("sd_c3", S_MEMADR, W_MA);
        tick(); mem_ready = 1'b0; cyc("sd_c4", S_MEMWR, W_WRD);
        tick(); mem_ready = 1'b1; cyc("sd_c5", S_MEMWR, W_WRD);

        // BNE then J: 3 cycles each.
        tick(); op = 6'b000101; cyc("bne_c1", S_FETCH, W_FR);
        tick(); cyc("bne_c2", S_DECODE, W_DEC);
        tick(); cyc("bne_c3", S_BRANCH, W_BNE);
        tick(); op = 6'b000010; cyc("j_c1", S_FETCH, W_FR);
        tick(); cyc("j_c2", S_DECODE, W_DEC);
        tick(); cyc("j_c3", S_JUMP, W_J);

        // ORI: aluop=or in execute and held through writeback.
        tick(); op = 6'b001101; cyc("ori_c1", S_FETCH, W_FR);
        tick(); cyc("ori_c2", S_DECODE, W_DEC);
        tick(); cyc("ori_c3", S_IEXEC, W_IEX);
        tick(); cyc("ori_c4", S_IWB, W_IWB);

        // SW interrupted by reset while MEMWR waits.
        tick(); op = 6'b101011; cyc("sw_c1", S_FETCH, W_FR);
        tick(); cyc("sw_c2", S_DECODE, W_DEC);
        tick(); cyc("sw_c3", S_MEMADR, W_MA);
        tick(); mem_ready = 1'b0; reset = 1'b0; cyc("sw_c4", S_MEMWR, W_WRW);
        tick(); reset = 1'b1; cyc("sw_rst", S_FETCH, W_FNR);

        // Undefined opcode traps and stays trapped until reset.
        mem_ready = 1'b1; op = 6'b111000;
        cyc("bad_c1", S_FETCH, W_FR);
        tick(); cyc("bad_c2", S_DECODE, W_DEC);
        tick(); cyc("bad_c3", S_TRAP, W_ILL);
        for (int i = 0; i < 4; i++) begin
            tick(); mem_ready = i[0]; op = 6'b000000;
            cyc("bad_hold", S_TRAP, W_ILL);
        end
        reset = 1'b0; mem_ready = 1'b0;
        tick(); reset = 1'b1; cyc("bad_rst", S_FETCH, W_FNR);
        tick(); cyc("bad_rst_wait", S_FETCH, W_FNR);

        // SD with EN64=0 must trap after DECODE and never write.
        op32 = 6'b111111; mem_ready32 = 1'b1;
        tick(); reset32 = 1'b1; cyc32("sd32_c1", S_FETCH, W_FR);
        tick(); cyc32("sd32_c2", S_DECODE, W_DEC);
        tick(); cyc32("sd32_c3", S_TRAP, W_ILL);
        for (int i = 0; i < 10; i++) begin
            tick(); cyc32("sd32_hold", S_TRAP, W_ILL);
        end
        check("sd32_no_memwrite", mw32_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
